// File: rtl/lab_pkg.sv
// rtl/lab_pkg.sv - shared mode encoding for lab datapath registers
package lab_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHR  = 2'b01;
  localparam mode_t MODE_SHL  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_counter.sv
// rtl/shift_counter.sv - modulo-WIDTH shift counter with registered wrap pulse
module shift_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // Count shifts; wrap pulses for one cycle on the edge that completes a word.
  // clr wins over inc so a load always restarts the word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (inc) begin
        if (cnt == LAST) begin
          cnt  <= '0;
          wrap <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal hold/shift/rotate/load register with word counter
module univ_shift_reg
  import lab_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rotate,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             done
);

  mode_t op;
  logic  in_r;
  logic  in_l;
  logic  is_shift;
  logic  is_load;

  assign op       = mode_t'(mode);
  // Rotation recirculates the bit falling off the opposite end.
  assign in_r     = rotate ? q[0]       : sin_r;
  assign in_l     = rotate ? q[WIDTH-1] : sin_l;
  assign is_shift = en && ((op == MODE_SHR) || (op == MODE_SHL));
  assign is_load  = en && (op == MODE_LOAD);

  assign sout_r   = q[0];
  assign sout_l   = q[WIDTH-1];

  // Data register: reset beats enable; hold when disabled or in hold mode.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= RST_VAL;
    end else if (en) begin
      case (op)
        MODE_SHR:  q <= {in_r, q[WIDTH-1:1]};
        MODE_SHL:  q <= {q[WIDTH-2:0], in_l};
        MODE_LOAD: q <= d;
        default:   q <= q;
      endcase
    end
  end

  shift_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_shift_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (is_load),
    .inc  (is_shift),
    .cnt  (shift_cnt),
    .wrap (done)
  );

endmodule
